// File: rtl/dht11_pkg.sv
// dht11_pkg
// Shared definitions for the DHT11 responder and its companions:
//   - FSM state encodings, also decoded by the LED status display
//   - default microsecond timing constants, shared with the host controller
//   - frame size and microsecond counter width
//   - the DHT11 checksum function
package dht11_pkg;

    // FSM encodings (4 bits so the LED display can show them directly)
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HOST_LOW  = 4'd1;
    localparam logic [3:0] ST_TURN      = 4'd2;
    localparam logic [3:0] ST_RESP_LOW  = 4'd3;
    localparam logic [3:0] ST_RESP_HIGH = 4'd4;
    localparam logic [3:0] ST_BIT_LOW   = 4'd5;
    localparam logic [3:0] ST_BIT_HIGH  = 4'd6;
    localparam logic [3:0] ST_EOF_LOW   = 4'd7;

    // Default protocol timing, in microseconds
    localparam int DEF_CLKS_PER_US  = 100;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_TURN_US      = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_ZERO_HIGH_US = 26;
    localparam int DEF_ONE_HIGH_US  = 70;

    // Frame: hum_int, hum_dec, tmp_int, tmp_dec, checksum
    localparam int FRAME_BITS = 40;

    // Wide enough for the longest phase (the start-pulse qualifier)
    localparam int US_W = 16;

    // Byte sum modulo 256
    function automatic logic [7:0] dht11_csum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b0 + b1 + b2 + b3;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick
// Microsecond prescaler. Emits a one-clock tick every CLKS_PER_US clocks.
// A synchronous restart forces the count back to zero, so the first tick
// after a restart arrives exactly CLKS_PER_US clocks later.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   restart  synchronous restart of the prescaler
//   tick     one-clock pulse per microsecond
module dht11_us_tick #(
    parameter int CLKS_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder
// Device-side DHT11 emulator. Qualifies a host start pulse on the open-drain
// line, answers with the 80/80 us handshake and serialises a 40-bit frame
// {hum_int, hum_dec, tmp_int, tmp_dec, csum}, MSB first.
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   dht_in        sensed bus level (asynchronous, 1 = high)
//   dht_oe        1 = pull the bus low, 0 = release (registered)
//   hum_int..tmp_dec  payload bytes, captured at start acceptance
//   csum_err_inj  invert checksum bit 0 for the frame being captured
//   busy          high from start acceptance until the frame ends
//   frame_done    one-cycle pulse at the end of a complete frame
//   abort         one-cycle pulse when a collision ends the frame
//   state         current FSM encoding for the LED display
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int TURN_US      = DEF_TURN_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int ZERO_HIGH_US = DEF_ZERO_HIGH_US,
    parameter int ONE_HIGH_US  = DEF_ONE_HIGH_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       csum_err_inj,
    output logic       busy,
    output logic       frame_done,
    output logic       abort,
    output logic [3:0] state
);

    // Last microsecond index of each timed phase
    localparam logic [US_W-1:0] START_LIM      = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] TURN_LAST      = US_W'(TURN_US - 1);
    localparam logic [US_W-1:0] RESP_LOW_LAST  = US_W'(RESP_LOW_US - 1);
    localparam logic [US_W-1:0] RESP_HIGH_LAST = US_W'(RESP_HIGH_US - 1);
    localparam logic [US_W-1:0] BIT_LOW_LAST   = US_W'(BIT_LOW_US - 1);
    localparam logic [US_W-1:0] ZERO_LAST      = US_W'(ZERO_HIGH_US - 1);
    localparam logic [US_W-1:0] ONE_LAST       = US_W'(ONE_HIGH_US - 1);
    localparam logic [5:0]      LAST_BIT       = 6'(FRAME_BITS - 1);

    logic [1:0]            sync_reg;
    logic                  bus_lvl;
    logic [3:0]            state_reg, state_next;
    logic [US_W-1:0]       us_cnt_reg;
    logic [5:0]            bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  dht_oe_reg, frame_done_reg, abort_reg;
    logic                  tick, restart;
    logic [US_W-1:0]       phase_last;
    logic                  phase_end, collision, host_low_sat, turn_entry, bit_advance;

    // Two-flop synchroniser; resets to the idle (high) bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], dht_in};
        end
    end
    assign bus_lvl = sync_reg[1];

    // Every state entry restarts the prescaler, so phases are exact multiples
    // of CLKS_PER_US clocks.
    assign restart = (state_next != state_reg);

    dht11_us_tick #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_us_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        phase_last = '0;
        case (state_reg)
            ST_TURN:      phase_last = TURN_LAST;
            ST_RESP_LOW:  phase_last = RESP_LOW_LAST;
            ST_RESP_HIGH: phase_last = RESP_HIGH_LAST;
            ST_BIT_LOW:   phase_last = BIT_LOW_LAST;
            ST_BIT_HIGH:  phase_last = shift_reg[FRAME_BITS-1] ? ONE_LAST : ZERO_LAST;
            ST_EOF_LOW:   phase_last = BIT_LOW_LAST;
            default:      phase_last = '0;
        endcase
    end

    assign phase_end    = tick && (us_cnt_reg == phase_last);
    assign host_low_sat = (us_cnt_reg >= START_LIM);

    // During the first microsecond of a released phase the synchroniser may
    // still show our own preceding low, so the bus is only trusted from tick 1.
    assign collision = ((state_reg == ST_RESP_HIGH) || (state_reg == ST_BIT_HIGH))
                       && (us_cnt_reg != '0) && !bus_lvl;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (!bus_lvl) state_next = ST_HOST_LOW;
            ST_HOST_LOW:  if (bus_lvl) state_next = host_low_sat ? ST_TURN : ST_IDLE;
            ST_TURN:      if (phase_end) state_next = ST_RESP_LOW;
            ST_RESP_LOW:  if (phase_end) state_next = ST_RESP_HIGH;
            ST_RESP_HIGH: begin
                if (collision)      state_next = ST_IDLE;
                else if (phase_end) state_next = ST_BIT_LOW;
            end
            ST_BIT_LOW:   if (phase_end) state_next = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (collision)      state_next = ST_IDLE;
                else if (phase_end) state_next = (bit_cnt_reg == LAST_BIT) ? ST_EOF_LOW : ST_BIT_LOW;
            end
            ST_EOF_LOW:   if (phase_end) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign turn_entry  = (state_next == ST_TURN) && (state_reg != ST_TURN);
    assign bit_advance = (state_reg == ST_BIT_HIGH) && (state_next == ST_BIT_LOW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            us_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            dht_oe_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Microsecond count within the current phase. Idle needs no
            // count, and the start qualifier saturates at its threshold.
            if (restart) begin
                us_cnt_reg <= '0;
            end else if (tick && (state_reg != ST_IDLE)
                         && !((state_reg == ST_HOST_LOW) && host_low_sat)) begin
                us_cnt_reg <= us_cnt_reg + 1'b1;
            end

            // Payload is frozen here; later input changes do not affect the frame
            if (turn_entry) begin
                bit_cnt_reg <= '0;
                shift_reg   <= {hum_int, hum_dec, tmp_int, tmp_dec,
                                dht11_csum(hum_int, hum_dec, tmp_int, tmp_dec)
                                ^ {7'd0, csum_err_inj}};
            end else if (bit_advance) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {shift_reg[FRAME_BITS-2:0], 1'b0};
            end

            // Driven from the next state so the pin changes with the state
            dht_oe_reg     <= (state_next == ST_RESP_LOW) || (state_next == ST_BIT_LOW)
                              || (state_next == ST_EOF_LOW);
            frame_done_reg <= (state_reg == ST_EOF_LOW) && (state_next == ST_IDLE);
            abort_reg      <= collision;
        end
    end

    assign dht_oe     = dht_oe_reg;
    assign frame_done = frame_done_reg;
    assign abort      = abort_reg;
    assign state      = state_reg;
    assign busy       = (state_reg >= ST_TURN);

endmodule

// File: doc/dht11_responder.md
# dht11_responder

- Device-side emulator of the DHT11 single-wire protocol.
- Watches the open-drain data line for a host start pulse and answers with the sensor handshake.
- Serialises a 40-bit frame: humidity int/dec, temperature int/dec, checksum.
- Used as the on-board/bench counterpart of the DHT11 host controller. Exports its FSM state so the LED status display can show responder progress.

## Interface
Parameters:
- CLKS_PER_US, 100, clocks per microsecond (100 MHz system clock)
- START_MIN_US, 18000, minimum host low time accepted as a start
- TURN_US, 30, delay after host release before responding
- RESP_LOW_US, 80, response low phase
- RESP_HIGH_US, 80, response high phase
- BIT_LOW_US, 50, low lead-in of every bit and of end-of-frame
- ZERO_HIGH_US, 26, high time for a '0'
- ONE_HIGH_US, 70, high time for a '1'

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; asynchronous and active-high
- dht_in  in  1  sensed bus level; asynchronous, 1 = high
- dht_oe  out  1  1 = pull bus low; 0 = release
- hum_int, hum_dec, tmp_int, tmp_dec  in  8 each  payload bytes
- csum_err_inj  in  1  when 1, checksum bit 0 is inverted for that frame
- busy  out  1  high from start acceptance until the frame ends
- frame_done  out  1  one-cycle pulse at the end of a frame
- abort  out  1  one-cycle pulse when a frame is aborted
- state  out  4  current FSM encoding, for LED display

## Operation
- dht_in passes through a 2-flop synchroniser. All decisions use the synchronised level.
- States and encodings: IDLE=0, HOST_LOW=1, TURN=2, RESP_LOW=3, RESP_HIGH=4, BIT_LOW=5, BIT_HIGH=6, EOF_LOW=7.
- IDLE: bus low → HOST_LOW. The µs counter clears on entry.
- HOST_LOW: counts µs while the bus is low. The counter saturates at START_MIN_US.
  - Bus high with count ≥ START_MIN_US → TURN.
  - Bus high with count < START_MIN_US → IDLE, no other effect.
- TURN entry:
  - Latch the 40-bit shift register: {hum_int, hum_dec, tmp_int, tmp_dec, csum}.
  - csum = (hum_int + hum_dec + tmp_int + tmp_dec) mod 256, XOR 8'h01 if csum_err_inj.
  - Payload inputs are ignored until the next TURN entry.
- Phase sequence and dht_oe level:
  - TURN: release.
  - RESP_LOW: low.
  - RESP_HIGH: release.
  - 40 × (BIT_LOW low, then BIT_HIGH release).
  - EOF_LOW: low.
  - Then IDLE, released.
- Bits go out MSB first. BIT_HIGH lasts ONE_HIGH_US if the current bit is 1, else ZERO_HIGH_US.
- A 6-bit bit counter runs 0..39. After bit 39's BIT_HIGH → EOF_LOW.
- Collision: in RESP_HIGH or BIT_HIGH, from µs tick 1 onward, a synchronised low means the bus is held by another party.
  - Response: abort pulse, dht_oe ← 0, go to IDLE.
- busy = 1 in states 2..7. frame_done pulses on the EOF_LOW → IDLE transition.

## Timing
- Reset values: dht_oe=0, busy=0, frame_done=0, abort=0, state=0, all counters 0, synchroniser flops 1 (idle bus).
- The µs prescaler restarts on every state entry, so each phase lasts exactly N × CLKS_PER_US clocks.
- Host release to dht_oe assertion = 2 sync clocks + 1 registered-transition clock + TURN_US × CLKS_PER_US.
- dht_oe is a flop output with no combinational path from dht_in.
- Frame length after TURN = 80 + 80 + 40×50 + Σ bit highs + 50 µs.
- Reset mid-frame releases the bus immediately (asynchronous) and returns to IDLE with no pulse.
- A start pulse arriving while busy is impossible without a collision; it is handled by the collision rule.

## Structure
- Package dht11_pkg holds:
  - state encodings shared with the LED display;
  - default µs timing constants shared with the host controller;
  - a checksum function.
- One sub-module: dht11_us_tick, a prescaler with a synchronous restart input that emits a one-clock tick every CLKS_PER_US clocks.

## Test plan
- **Normal frame:** 18.5 ms host low, then release; payload 0x37, 0x00, 0x19, 0x05.
  - Checksum 0x55.
  - 80/80 µs response.
  - Decoded 40 bits = 0x3700190555.
  - frame_done pulses once.
- **Short start:** host low 10 ms, then release.
  - dht_oe stays 0, busy stays 0, state returns to 0.
- **Checksum injection:** same payload with csum_err_inj=1.
  - Last byte decoded = 0x54; other bytes unchanged.
- **Payload change mid-frame:** change hum_int to 0xFF during bit 3.
  - Transmitted frame still starts with 0x37.
- **Collision:** bench drives the bus low 5 µs into bit 10's BIT_HIGH.
  - One abort pulse, dht_oe=0, state=0, no frame_done.
- **Reset mid-frame:** assert rst during RESP_LOW.
  - dht_oe=0 in the same cycle; all outputs at reset values.
  - A following valid start yields a full correct frame.
